// File: rtl/hazard_pkg.sv
// Package for the hazard control sequencer: FSM state encoding, default
// parameter values and a helper that sizes the internal down-counter.
package hazard_pkg;

    // FSM states of hazard_ctrl_seq
    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MD_WAIT    = 2'd2,
        ST_EXC_DRAIN  = 2'd3
    } hz_state_t;

    localparam int DEF_ADDR_W        = 4;
    localparam int DEF_LOAD_STALL    = 1;
    localparam int DEF_MD_CYCLES     = 8;
    localparam int DEF_EXC_DRAIN     = 2;
    localparam int DEF_ZERO_REG_FREE = 1;
    localparam int DEF_CNT_W         = 16;

    // Width of the shared down-counter: 3 bits cover the 1..7 ranges,
    // a long mul/div needs the full 8 bits.
    function automatic int cnt_width(input int md_cycles,
                                     input int load_stall,
                                     input int exc_drain);
        if ((md_cycles > 7) || (load_stall > 7) || (exc_drain > 7)) begin
            return 8;
        end else begin
            return 3;
        end
    endfunction

endpackage

// File: rtl/hazard_stall_counter.sv
// Saturating performance counter.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset (clears the count)
//   en    - count this cycle
//   count - current count, holds at all-ones
module hazard_stall_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    // Count enabled cycles, stop at the maximum value instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= {CNT_W{1'b0}};
        end else if (en && (count != {CNT_W{1'b1}})) begin
            count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/hazard_ctrl_seq.sv
// Pipeline hazard sequencer: load-use stalls of configurable depth,
// multi-cycle mul/div front-end stall, branch flush, overflow drain, and
// a saturating stall-cycle counter. Outputs are combinational on top of
// the registered FSM state.
// Ports:
//   clk, rst_n                  - clock / asynchronous active-low reset
//   if_id_op1, if_id_op2        - source registers of the instruction in ID
//   id_ex_op1                   - destination register of the instruction in EX
//   id_ex_mem_read              - EX instruction is a load
//   md_start                    - mul/div entering EX (one-cycle pulse)
//   over_flow                   - EX overflow exception
//   branch_jump_flag            - taken branch/jump resolved in EX
//   pc_write, if_id_write, id_ex_write - pipeline register enables
//   if_id_flash, id_hazard_flash, ex_flash - flush controls
//   md_busy                     - mul/div stall in progress
//   stall_count                 - saturating count of PC-stalled cycles
module hazard_ctrl_seq
    import hazard_pkg::*;
#(
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int LOAD_STALL    = DEF_LOAD_STALL,
    parameter int MD_CYCLES     = DEF_MD_CYCLES,
    parameter int EXC_DRAIN     = DEF_EXC_DRAIN,
    parameter int ZERO_REG_FREE = DEF_ZERO_REG_FREE,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] if_id_op1,
    input  logic [ADDR_W-1:0] if_id_op2,
    input  logic [ADDR_W-1:0] id_ex_op1,
    input  logic              id_ex_mem_read,
    input  logic              md_start,
    input  logic              over_flow,
    input  logic              branch_jump_flag,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              id_ex_write,
    output logic              if_id_flash,
    output logic              id_hazard_flash,
    output logic              ex_flash,
    output logic              md_busy,
    output logic [CNT_W-1:0]  stall_count
);

    localparam int CW = cnt_width(MD_CYCLES, LOAD_STALL, EXC_DRAIN);

    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] MD_LOAD   = CW'(MD_CYCLES - 1);
    localparam logic [CW-1:0] LS_LOAD   = CW'(LOAD_STALL - 1);
    localparam logic [CW-1:0] EXC_LOAD  = CW'(EXC_DRAIN - 1);

    hz_state_t     state_r;
    hz_state_t     state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          hit_s;

    logic pc_write_s;
    logic if_id_write_s;
    logic id_ex_write_s;
    logic if_id_flash_s;
    logic id_hazard_flash_s;
    logic ex_flash_s;
    logic md_busy_s;

    // Load-use match on full register addresses; r0 optionally exempt
    always_comb begin
        hit_s = 1'b0;
        if (id_ex_mem_read &&
            ((id_ex_op1 == if_id_op1) || (id_ex_op1 == if_id_op2)) &&
            !((ZERO_REG_FREE != 0) && (id_ex_op1 == {ADDR_W{1'b0}}))) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
    end

    // State and down-counter registers; reset always resumes in RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state and output decode, overflow taking precedence everywhere
    always_comb begin
        state_nxt_s       = state_r;
        cnt_nxt_s         = cnt_r;
        pc_write_s        = 1'b1;
        if_id_write_s     = 1'b1;
        id_ex_write_s     = 1'b1;
        if_id_flash_s     = 1'b0;
        id_hazard_flash_s = 1'b0;
        ex_flash_s        = 1'b0;
        md_busy_s         = 1'b0;

        if (over_flow) begin
            // Vector load: PC keeps writing while everything younger is squashed
            if_id_flash_s     = 1'b1;
            id_hazard_flash_s = 1'b1;
            ex_flash_s        = 1'b1;
            if (EXC_DRAIN > 1) begin
                state_nxt_s = ST_EXC_DRAIN;
                cnt_nxt_s   = EXC_LOAD;
            end else begin
                state_nxt_s = ST_RUN;
                cnt_nxt_s   = {CW{1'b0}};
            end
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (branch_jump_flag) begin
                        if_id_flash_s     = 1'b1;
                        id_hazard_flash_s = 1'b1;
                        state_nxt_s       = ST_RUN;
                    end else if (md_start) begin
                        pc_write_s    = 1'b0;
                        if_id_write_s = 1'b0;
                        id_ex_write_s = 1'b0;
                        md_busy_s     = 1'b1;
                        state_nxt_s   = ST_MD_WAIT;
                        cnt_nxt_s     = MD_LOAD;
                    end else if (hit_s) begin
                        pc_write_s        = 1'b0;
                        if_id_write_s     = 1'b0;
                        id_hazard_flash_s = 1'b1;
                        if (LOAD_STALL > 1) begin
                            state_nxt_s = ST_LOAD_STALL;
                            cnt_nxt_s   = LS_LOAD;
                        end else begin
                            state_nxt_s = ST_RUN;
                        end
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end

                ST_LOAD_STALL: begin
                    // The match is not re-evaluated here; only a branch cancels
                    if (branch_jump_flag) begin
                        if_id_flash_s     = 1'b1;
                        id_hazard_flash_s = 1'b1;
                        state_nxt_s       = ST_RUN;
                        cnt_nxt_s         = {CW{1'b0}};
                    end else begin
                        pc_write_s        = 1'b0;
                        if_id_write_s     = 1'b0;
                        id_hazard_flash_s = 1'b1;
                        if (cnt_r == CNT_ONE) begin
                            state_nxt_s = ST_RUN;
                            cnt_nxt_s   = {CW{1'b0}};
                        end else begin
                            cnt_nxt_s = cnt_r - CNT_ONE;
                        end
                    end
                end

                ST_MD_WAIT: begin
                    // Branches and further md_start pulses are ignored here
                    pc_write_s    = 1'b0;
                    if_id_write_s = 1'b0;
                    id_ex_write_s = 1'b0;
                    md_busy_s     = 1'b1;
                    if (cnt_r == CNT_ONE) begin
                        state_nxt_s = ST_RUN;
                        cnt_nxt_s   = {CW{1'b0}};
                    end else begin
                        cnt_nxt_s = cnt_r - CNT_ONE;
                    end
                end

                ST_EXC_DRAIN: begin
                    if_id_flash_s     = 1'b1;
                    id_hazard_flash_s = 1'b1;
                    if (cnt_r == CNT_ONE) begin
                        state_nxt_s = ST_RUN;
                        cnt_nxt_s   = {CW{1'b0}};
                    end else begin
                        cnt_nxt_s = cnt_r - CNT_ONE;
                    end
                end

                default: begin
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = {CW{1'b0}};
                end
            endcase
        end
    end

    // Outputs take their reset values immediately while rst_n is low
    always_comb begin
        if (!rst_n) begin
            pc_write        = 1'b0;
            if_id_write     = 1'b0;
            id_ex_write     = 1'b0;
            if_id_flash     = 1'b1;
            id_hazard_flash = 1'b1;
            ex_flash        = 1'b0;
            md_busy         = 1'b0;
        end else begin
            pc_write        = pc_write_s;
            if_id_write     = if_id_write_s;
            id_ex_write     = id_ex_write_s;
            if_id_flash     = if_id_flash_s;
            id_hazard_flash = id_hazard_flash_s;
            ex_flash        = ex_flash_s;
            md_busy         = md_busy_s;
        end
    end

    hazard_stall_counter #(
        .CNT_W (CNT_W)
    ) u_stall_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (~pc_write),
        .count (stall_count)
    );

endmodule
